// File: rtl/gate_tester.sv
// gate_tester: drives the four input combinations of a 2-input gate under
// test, waits SETTLE cycles after each change, samples y_in and compares it
// against the truth table of the gate type latched at start. It reports a
// per-vector fail mask, a saturating mismatch count and a pass flag.
//
// Optional feature: define GATE_TESTER_EARLY_ABORT_EN to finish the run on
// the first mismatching vector instead of always applying all four vectors.
module gate_tester #(
  parameter int SETTLE = 1  // hold cycles before y_in is sampled, 1..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  // Gate type codes as seen on gate_sel.
  localparam logic [2:0] GATE_AND  = 3'd0;
  localparam logic [2:0] GATE_OR   = 3'd1;
  localparam logic [2:0] GATE_NAND = 3'd2;
  localparam logic [2:0] GATE_NOR  = 3'd3;
  localparam logic [2:0] GATE_XOR  = 3'd4;
  localparam logic [2:0] GATE_XNOR = 3'd5;
  localparam logic [2:0] GATE_BUF  = 3'd6;

  // Counter reload value; SETTLE always fits in four bits.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);

  // Mismatch count saturates here (there are only four vectors).
  localparam logic [2:0] ERR_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] gate_q, gate_d;     // gate type captured at the start edge
  logic [1:0] vec_q, vec_d;       // current vector, {a_out,b_out}
  logic [3:0] cnt_q, cnt_d;       // settle countdown while in WAIT
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;

  // Expected output of a gate type for one input combination.
  function automatic logic gate_eval(input logic [2:0] g, input logic a, input logic b);
    logic y;
    case (g)
      GATE_AND:  y = a & b;
      GATE_OR:   y = a | b;
      GATE_NAND: y = ~(a & b);
      GATE_NOR:  y = ~(a | b);
      GATE_XOR:  y = a ^ b;
      GATE_XNOR: y = ~(a ^ b);
      GATE_BUF:  y = a;
      default:   y = ~a;       // NOT
    endcase
    return y;
  endfunction

  // Full truth table of the latched gate, bit index = {a,b}.
  logic [3:0] exp_tt;

  for (genvar gi = 0; gi < 4; gi++) begin : g_tt
    localparam logic [1:0] VEC = 2'(gi);
    assign exp_tt[gi] = gate_eval(gate_q, VEC[1], VEC[0]);
  end

  // Result of comparing y_in with the expected value of the current vector.
  logic       mismatch;
  logic [2:0] err_sample;
  logic [3:0] fail_sample;
  logic       last_vec;

  // Per-sample bookkeeping: mismatch flag, updated count/mask, end-of-run test.
  always_comb begin
    mismatch    = (y_in != exp_tt[vec_q]);
    err_sample  = err_q;
    fail_sample = fail_q;
    if (mismatch) begin
      err_sample  = (err_q >= ERR_MAX) ? ERR_MAX : err_q + 3'd1;
      fail_sample = fail_q | (4'(mismatch) << vec_q);
    end
`ifdef GATE_TESTER_EARLY_ABORT_EN
    last_vec = (vec_q == 2'd3) || mismatch;
`else
    last_vec = (vec_q == 2'd3);
`endif
  end

  // Next-state and output-register logic of the run sequencer.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fail_d  = fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_d  = gate_sel;
          vec_d   = 2'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          err_d   = 3'd0;
          fail_d  = 4'd0;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Spend exactly SETTLE cycles here; the sample edge follows.
        if (cnt_q <= 4'd1) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        err_d  = err_sample;
        fail_d = fail_sample;
        if (last_vec) begin
          // Results become visible together with the done pulse.
          done_d  = 1'b1;
          busy_d  = 1'b0;
          vec_d   = 2'd0;
          pass_d  = (err_sample == 3'd0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = ST_WAIT;
        end
      end

      ST_DONE: begin
        // start is deliberately ignored here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gate_q  <= 3'd0;
      vec_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
    end
  end

  assign a_out     = vec_q[1];
  assign b_out     = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// Bench for gate_tester: two instances (SETTLE=1 and SETTLE=3), each with a
// bench-modelled gate under test given as a 4-entry truth table. Expected
// run results go into a scoreboard queue when a run is started; a monitor
// checks vector sequencing every cycle and pops/compares on each done pulse.
module tb_gate_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [1:0]      start;
  logic [1:0][2:0] gsel;
  logic [1:0]      y_in;
  logic [1:0]      a_out, b_out, busy, done, pass;
  logic [1:0][2:0] err_count;
  logic [1:0][3:0] fail_vec;

  // Gate under test per instance: truth table indexed by {a,b}.
  logic [1:0][3:0] gut_tt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign y_in[gi] = gut_tt[gi][{a_out[gi], b_out[gi]}];

    gate_tester #(.SETTLE(gi == 0 ? 1 : 3)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[gi]),
      .gate_sel (gsel[gi]),
      .y_in     (y_in[gi]),
      .a_out    (a_out[gi]),
      .b_out    (b_out[gi]),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .pass     (pass[gi]),
      .err_count(err_count[gi]),
      .fail_vec (fail_vec[gi])
    );
  end

  typedef struct {
    int       inst;
    logic [3:0] fail;
    int       err;
    int       pass;
    int       lat;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] tt_ref[8];
  int         cyc = 0;
  int         start_edge[2];
  bit         run_active[2];
  int         total = 0;
  int         bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference result of a run, from the truth tables and the timing rules.
  function automatic exp_t model(input int i, input logic [2:0] sel, input logic [3:0] tt);
    exp_t       e;
    logic [3:0] diff;
    int         s1;
    diff   = tt_ref[sel] ^ tt;
    s1     = settle_of(i) + 1;
    e.inst = i;
    e.pass = (diff == 4'd0) ? 1 : 0;
`ifdef GATE_TESTER_EARLY_ABORT_EN
    e.fail = 4'd0;
    e.err  = 0;
    e.lat  = 4 * s1;
    for (int k = 3; k >= 0; k--) begin
      if (diff[k]) begin
        e.fail = 4'd1 << k;
        e.err  = 1;
        e.lat  = (k + 1) * s1;
      end
    end
`else
    e.fail = diff;
    e.err  = $countones(diff);
    e.lat  = 4 * s1;
`endif
    return e;
  endfunction

  // Monitor: per-cycle vector/busy checks during a run, compare on done.
  always @(negedge clk) begin
    int   el;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (run_active[i]) begin
        el = cyc - start_edge[i];
        if (done[i]) begin
          e = sb.pop_front();
          chk("done_inst", i, e.inst);
          chk("done_latency", el, e.lat);
          chk("err_count", int'(err_count[i]), e.err);
          chk("fail_vec", int'(fail_vec[i]), int'(e.fail));
          chk("pass", int'(pass[i]), e.pass);
          chk("busy_at_done", int'(busy[i]), 0);
          chk("ab_at_done", int'({a_out[i], b_out[i]}), 0);
          $display("run inst=%0d latency=%0d err=%0d fail_vec=%b pass=%0d",
                   i, el, err_count[i], fail_vec[i], pass[i]);
          run_active[i] = 1'b0;
        end else if (sb.size() > 0) begin
          if (el < sb[0].lat) begin
            chk("busy_in_run", int'(busy[i]), 1);
            chk("vector", int'({a_out[i], b_out[i]}), el / (settle_of(i) + 1));
          end else if (el == sb[0].lat) begin
            chk("done_pulse", int'(done[i]), 1);
          end
        end
      end else if (done[i]) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: inst %0d got done=1, expected 0 (cycle %0d)", i, cyc);
      end
    end
  end

  task automatic check_zero(input int i, input string tag);
    chk({tag, "_a"}, int'(a_out[i]), 0);
    chk({tag, "_b"}, int'(b_out[i]), 0);
    chk({tag, "_busy"}, int'(busy[i]), 0);
    chk({tag, "_done"}, int'(done[i]), 0);
    chk({tag, "_pass"}, int'(pass[i]), 0);
    chk({tag, "_err"}, int'(err_count[i]), 0);
    chk({tag, "_fail"}, int'(fail_vec[i]), 0);
  endtask

  // One complete run; inputs change only #1 after a rising edge.
  task automatic run_test(input int i, input logic [2:0] sel, input logic [3:0] tt,
                          input bit hold, input bit toggle);
    int n;
    gut_tt[i] = tt;
    gsel[i]   = sel;
    start[i]  = 1'b1;
    sb.push_back(model(i, sel, tt));
    @(posedge clk);
    #1;
    start_edge[i] = cyc;
    run_active[i] = 1'b1;
    if (!hold) start[i] = 1'b0;
    n = 0;
    while (run_active[i] && n < 100) begin
      @(posedge clk);
      #1;
      if (toggle) gsel[i] = 3'($urandom);
      n++;
    end
    start[i] = 1'b0;
    if (run_active[i]) begin
      total++;
      bad++;
      $display("FAIL timeout: inst %0d got no done within 100 cycles, expected done", i);
      run_active[i] = 1'b0;
      void'(sb.pop_front());
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("single_run_idle", int'(busy[i]), 0);
  endtask

  initial begin
    exp_t e;
    logic [2:0] sel;
    logic [3:0] tt;
    int i;

    tt_ref = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
               4'b0110, 4'b1001, 4'b1100, 4'b0011};
    rst        = 1'b1;
    start      = '0;
    gsel       = '0;
    gut_tt     = '0;
    run_active = '{1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check_zero(0, "reset0");
    check_zero(1, "reset1");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Correct NOR, expected NOR: clean pass.
    run_test(0, 3'd3, tt_ref[3], 1'b0, 1'b0);
    // Expected NOR, y_in stuck at 0: only vector 00 fails.
    run_test(0, 3'd3, 4'b0000, 1'b0, 1'b0);
    // Expected NAND against a NOR gate.
    run_test(0, 3'd2, tt_ref[3], 1'b0, 1'b0);
    run_test(1, 3'd2, tt_ref[3], 1'b0, 1'b0);

    // Reset five cycles into a run: all outputs clear, no done afterwards.
    gut_tt[0] = tt_ref[3];
    gsel[0]   = 3'd3;
    start[0]  = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    start_edge[0] = cyc;
    sb.push_back(model(0, 3'd3, tt_ref[3]));
    run_active[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_active[0] = 1'b0;
    e = sb.pop_back();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero(0, "abort");
    repeat (12) @(posedge clk);
    #1;
    run_test(0, 3'd3, tt_ref[3], 1'b0, 1'b0);

    // SETTLE=3, start held high and gate_sel toggled throughout.
    run_test(1, 3'd3, tt_ref[3], 1'b1, 1'b1);
    run_test(1, 3'd4, 4'b1111, 1'b1, 1'b1);

    // Randomized runs on both instances.
    for (int r = 0; r < 40; r++) begin
      i   = $urandom_range(0, 1);
      sel = 3'($urandom_range(0, 7));
      tt  = ($urandom_range(0, 1) == 0) ? tt_ref[sel] : 4'($urandom);
      run_test(i, sel, tt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
